// File: rtl/fpu_normalize_round_if.sv
// Handshake bundle between the FPU add/sub mantissa datapath and the
// normalise-and-round stage: operand beat in, packed single result out.
interface fpu_normalize_round_if #(
    parameter int EXP_W = 10
);
    logic             in_valid;
    logic             in_ready;
    logic [26:0]      in_mant;
    logic             in_sticky;
    logic [EXP_W-1:0] in_exp;
    logic             in_sign;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic             out_ovf;
    logic             out_unf;
    logic             out_zero;

    modport master (
        output in_valid, in_mant, in_sticky, in_exp, in_sign, out_ready,
        input  in_ready, out_valid, out_result, out_ovf, out_unf, out_zero
    );

    modport slave (
        input  in_valid, in_mant, in_sticky, in_exp, in_sign, out_ready,
        output in_ready, out_valid, out_result, out_ovf, out_unf, out_zero
    );
endinterface

// File: rtl/fpu_normalize_round.sv
// Multicycle normalise / round-to-nearest-even / re-bias stage producing a
// packed IEEE-754 single; one bit of normalisation shift per clock.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for an operand, in_ready high
// S_SHIFT | normalising: carry right-shift, or one left shift per cycle
// S_ROUND | RNE increment, exponent re-bias, overflow/underflow decision
// S_DONE  | result presented, held until out_ready
module fpu_normalize_round #(
    parameter int EXP_W = 10,
    parameter int BIAS  = 127
) (
    input  logic                 clk,
    input  logic                 arst_n,
    fpu_normalize_round_if.slave bus,
    output logic                 busy
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic signed [EXP_W-1:0] EXP_MIN  = EXP_W'(1 - BIAS);
    localparam logic signed [EXP_W-1:0] EXP_BIAS = EXP_W'(BIAS);
    localparam logic signed [EXP_W-1:0] EXP_INF  = EXP_W'(255);
    localparam logic signed [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
    localparam logic signed [EXP_W-1:0] EXP_ZERO = EXP_W'(0);

    state_t                  state_q, state_d;
    logic [26:0]             mant_q, mant_d;
    logic                    sticky_q, sticky_d;
    logic signed [EXP_W-1:0] exp_q, exp_d;
    logic                    sign_q, sign_d;
    logic [31:0]             result_q, result_d;
    logic                    ovf_q, ovf_d;
    logic                    unf_q, unf_d;
    logic                    zero_q, zero_d;

    logic                    rnd_up;
    logic [24:0]             rnd_sum;
    logic signed [EXP_W-1:0] rnd_exp;
    logic signed [EXP_W-1:0] rnd_biased;
    logic [22:0]             rnd_frac;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= S_IDLE;
            mant_q   <= '0;
            sticky_q <= 1'b0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mant_q   <= mant_d;
            sticky_q <= sticky_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            zero_q   <= zero_d;
        end
    end

    // On a rounding carry the sum is exactly 1.000..0, so sum[23:1] is the
    // zero fraction of the incremented exponent.
    always_comb begin
        rnd_up     = mant_q[1] & (mant_q[0] | sticky_q | mant_q[2]);
        rnd_sum    = {1'b0, mant_q[25:2]} + {24'd0, rnd_up};
        rnd_exp    = rnd_sum[24] ? exp_q + EXP_ONE : exp_q;
        rnd_biased = rnd_exp + EXP_BIAS;
        rnd_frac   = rnd_sum[24] ? rnd_sum[23:1] : rnd_sum[22:0];
    end

    always_comb begin
        state_d  = state_q;
        mant_d   = mant_q;
        sticky_d = sticky_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        zero_d   = zero_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    mant_d   = bus.in_mant;
                    sticky_d = bus.in_sticky;
                    exp_d    = bus.in_exp;
                    sign_d   = bus.in_sign;
                    result_d = '0;
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    zero_d   = 1'b0;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (mant_q == 27'd0) begin
                    result_d = {sign_q, 31'd0};
                    zero_d   = 1'b1;
                    state_d  = S_DONE;
                end else if (mant_q[26]) begin
                    mant_d   = {1'b0, mant_q[26:1]};
                    sticky_d = sticky_q | mant_q[0];
                    exp_d    = exp_q + EXP_ONE;
                    state_d  = S_ROUND;
                end else if (!mant_q[25] && exp_q == EXP_MIN) begin
                    // No denormal support: anything below the normal range flushes.
                    result_d = {sign_q, 31'd0};
                    unf_d    = 1'b1;
                    zero_d   = 1'b1;
                    state_d  = S_DONE;
                end else if (!mant_q[25]) begin
                    mant_d   = {mant_q[25:0], 1'b0};
                    exp_d    = exp_q - EXP_ONE;
                end else begin
                    state_d  = S_ROUND;
                end
            end
            S_ROUND: begin
                if (rnd_biased >= EXP_INF) begin
                    result_d = {sign_q, 8'hFF, 23'd0};
                    ovf_d    = 1'b1;
                end else if (rnd_biased <= EXP_ZERO) begin
                    result_d = {sign_q, 31'd0};
                    unf_d    = 1'b1;
                    zero_d   = 1'b1;
                end else begin
                    result_d = {sign_q, rnd_biased[7:0], rnd_frac};
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    result_d = '0;
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    zero_d   = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.out_valid  = (state_q == S_DONE);
    assign bus.out_result = result_q;
    assign bus.out_ovf    = ovf_q;
    assign bus.out_unf    = unf_q;
    assign bus.out_zero   = zero_q;
    assign busy           = (state_q != S_IDLE);
endmodule
